// File: rtl/wb_register_file_pkg.sv
// rtl/wb_register_file_pkg.sv - shared write-back stage constants and bus type
package wb_register_file_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int REG_ZERO = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] value;
  } wb_bus_t;

endpackage

// File: rtl/wb_regfile_read_port.sv
// rtl/wb_regfile_read_port.sv - combinational read port with r0 masking and WB bypass
module wb_regfile_read_port #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] row_data,
  input  logic              wb_commit,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_value,
  output logic [DATA_W-1:0] rd_data
);
  import wb_register_file_pkg::*;

  // wb_commit is already qualified by enable, nonzero address and reset,
  // so an idle WB stage can never steer its address/value onto the output.
  always_comb begin
    rd_data = row_data;
    if (rd_addr == ADDR_W'(REG_ZERO)) begin
      rd_data = '0;
    end else if (wb_commit && (wb_addr == rd_addr)) begin
      rd_data = wb_value;
    end
  end

endmodule

// File: rtl/wb_register_file.sv
// rtl/wb_register_file.sv - GPR file with WB-to-ID bypass and committed-write counter
module wb_register_file #(
  parameter int DATA_W   = wb_register_file_pkg::DATA_W,
  parameter int ADDR_W   = wb_register_file_pkg::ADDR_W,
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] write_regAddress_WB,
  input  logic              is_write_WB,
  input  logic [DATA_W-1:0] write_regValue_WB,
  input  logic [ADDR_W-1:0] read_addrA_ID,
  input  logic [ADDR_W-1:0] read_addrB_ID,
  output logic [DATA_W-1:0] read_dataA_ID,
  output logic [DATA_W-1:0] read_dataB_ID,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [CNT_W-1:0]  write_count
);
  import wb_register_file_pkg::*;

  if (NUM_REGS != (1 << ADDR_W)) begin : g_bad_num_regs
    $error("wb_register_file: NUM_REGS must equal 2**ADDR_W");
  end

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic              commit;

  // Gating with reset keeps outputs at zero during reset and drops writes.
  assign commit = is_write_WB && (write_regAddress_WB != ADDR_W'(REG_ZERO)) && !reset;

  always_comb begin
    regs_d  = regs_q;
    count_d = count_q;
    if (commit) begin
      regs_d[write_regAddress_WB] = write_regValue_WB;
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      count_q <= count_d;
    end
  end

  assign write_count = count_q;

  wb_regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_a (
    .rd_addr  (read_addrA_ID),
    .row_data (regs_q[read_addrA_ID]),
    .wb_commit(commit),
    .wb_addr  (write_regAddress_WB),
    .wb_value (write_regValue_WB),
    .rd_data  (read_dataA_ID)
  );

  wb_regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_b (
    .rd_addr  (read_addrB_ID),
    .row_data (regs_q[read_addrB_ID]),
    .wb_commit(commit),
    .wb_addr  (write_regAddress_WB),
    .wb_value (write_regValue_WB),
    .rd_data  (read_dataB_ID)
  );

  wb_regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_dbg (
    .rd_addr  (dbg_addr),
    .row_data (regs_q[dbg_addr]),
    .wb_commit(commit),
    .wb_addr  (write_regAddress_WB),
    .wb_value (write_regValue_WB),
    .rd_data  (dbg_data)
  );

endmodule
